// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared widths, writeback source indices and register-zero constant
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Writeback source indices, also the values held by the round-robin pointer
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  // Writes to this register are accepted but never reach the register file
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-requester round-robin arbiter with one-hot grant and pointer
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic r_rr;
  logic w_contend;

  assign w_contend = req[SRC_ALU] & req[SRC_MEM];

  // Grant: nothing under hold, the lone requester, or the pointer's pick on contention
  always_comb begin
    grant = 2'b00;
    if (!hold) begin
      if (w_contend) begin
        grant = r_rr ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // Pointer moves to the loser only when a contended grant actually happens
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr <= 1'(SRC_ALU);
    end else if (!hold && w_contend) begin
      r_rr <= grant[SRC_ALU] ? 1'(SRC_MEM) : 1'(SRC_ALU);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_write_arbiter
// Brief   : Arbitrates ALU and memory writebacks onto the single register-file
//           write port, with a registered output stage and read bypass
// Revision: 1.0 - initial release
// ============================================================================
module wb_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluAddr,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic              byp1,
  output logic              byp2,
  output logic [DATA_W-1:0] bypData1,
  output logic [DATA_W-1:0] bypData2
);

  logic [1:0]        w_grant;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selData;
  logic              w_load;
  logic              r_writeEnable;
  logic [ADDR_W-1:0] r_writeAddr;
  logic [DATA_W-1:0] r_writeData;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .req   ({memValid, aluValid}),
    .grant (w_grant)
  );

  assign aluReady = w_grant[SRC_ALU];
  assign memReady = w_grant[SRC_MEM];

  // Winner's request; register-zero grants are consumed without loading a write
  assign w_selAddr = w_grant[SRC_MEM] ? memAddr : aluAddr;
  assign w_selData = w_grant[SRC_MEM] ? memData : aluData;
  assign w_load    = (|w_grant) && (w_selAddr != ADDR_W'(REG_ZERO));

  // Output stage: address and data are zeroed whenever no write is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_writeEnable <= 1'b0;
      r_writeAddr   <= '0;
      r_writeData   <= '0;
    end else if (w_load) begin
      r_writeEnable <= 1'b1;
      r_writeAddr   <= w_selAddr;
      r_writeData   <= w_selData;
    end else begin
      r_writeEnable <= 1'b0;
      r_writeAddr   <= '0;
      r_writeData   <= '0;
    end
  end

  assign writeEnable = r_writeEnable;
  assign writeAddr   = r_writeAddr;
  assign writeData   = r_writeData;

  // Bypass the write in flight to readers of the same non-zero register
  always_comb begin
    byp1     = r_writeEnable && (r_writeAddr == readAddr1) && (readAddr1 != ADDR_W'(REG_ZERO));
    byp2     = r_writeEnable && (r_writeAddr == readAddr2) && (readAddr2 != ADDR_W'(REG_ZERO));
    bypData1 = byp1 ? r_writeData : '0;
    bypData2 = byp2 ? r_writeData : '0;
  end

endmodule
`default_nettype wire
